// File: rtl/seq_scan_pkg.sv
// Shared definitions for the serial scan controller: state encoding,
// parameter defaults and the counter-width helper.
package seq_scan_pkg;

    localparam int   WORD_W_DEF   = 8;
    localparam int   CNT_W_DEF    = 4;
    localparam int   DET_LAT_DEF  = 2;
    localparam logic IDLE_BIT_DEF = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_REPORT = 3'd4
    } state_e;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word-in / result-out handshake bundle of the scan controller.
interface seq_scan_ctrl_if
    import seq_scan_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_keep;
    logic              in_ready;
    logic              out_valid;
    logic [CNT_W-1:0]  out_count;
    logic              out_ready;

    modport master (
        output in_valid, in_data, in_keep, out_ready,
        input  in_ready, out_valid, out_count
    );

    modport slave (
        input  in_valid, in_data, in_keep, out_ready,
        output in_ready, out_valid, out_count
    );
endinterface

// File: rtl/seq_scan_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        // NOTE: default assigned first so every path drives count_d; no latch is inferred.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/seq_scan_ctrl.sv
// Serialises a word MSB-first into an external detector, drains its latency
// and reports how many cycles the detector fired.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int   WORD_W   = WORD_W_DEF,
    parameter int   CNT_W    = CNT_W_DEF,
    parameter int   DET_LAT  = DET_LAT_DEF,
    parameter logic IDLE_BIT = IDLE_BIT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    seq_scan_ctrl_if.slave bus,
    output logic           det_din,
    output logic           det_clear,
    input  logic           det_y,
    output logic           busy
);
    localparam int BIT_W = cnt_w(WORD_W - 1);
    localparam int DRN_W = cnt_w(DET_LAT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DET_LAT - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DRN_W-1:0]  drn_q, drn_d;

    logic             accept;
    logic             cnt_en;
    logic             cnt_clr;
    logic [CNT_W-1:0] count;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             det_din_c;
    logic             det_clear_c;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bit_d       = bit_q;
        drn_d       = drn_q;
        accept      = 1'b0;
        cnt_en      = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        det_din_c   = IDLE_BIT;
        det_clear_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    sreg_d  = bus.in_data;
                    bit_d   = '0;
                    state_d = bus.in_keep ? ST_SHIFT : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                det_clear_c = 1'b1;
                state_d     = ST_SHIFT;
            end
            ST_SHIFT: begin
                det_din_c = sreg_q[WORD_W-1];
                sreg_d    = sreg_q << 1;
                cnt_en    = det_y;
                if (bit_q == BIT_LAST) begin
                    drn_d   = '0;
                    state_d = (DET_LAT == 0) ? ST_REPORT : ST_DRAIN;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            ST_DRAIN: begin
                cnt_en = det_y;
                if (drn_q == DRN_LAST) begin
                    state_d = ST_REPORT;
                end else begin
                    drn_d = drn_q + DRN_W'(1);
                end
            end
            ST_REPORT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset overrides the outputs combinationally so they are safe before the first edge.
        if (reset) begin
            accept      = 1'b0;
            cnt_en      = 1'b0;
            in_ready_c  = 1'b0;
            out_valid_c = 1'b0;
            det_din_c   = IDLE_BIT;
            det_clear_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            // NOTE: the datapath registers are cleared too, so an aborted word leaves nothing behind.
            sreg_q  <= '0;
            bit_q   <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bit_q   <= bit_d;
            drn_q   <= drn_d;
        end
    end

    assign cnt_clr = reset || accept;

    sat_counter #(.W(CNT_W)) u_count (
        .clk   (clk),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_count = out_valid_c ? count : '0;
    assign det_din       = det_din_c;
    assign det_clear     = det_clear_c;
    assign busy          = (state_q != ST_IDLE) && !reset;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: an offset-timeline model checks two instances
// (8- and 16-bit words) every cycle, plus hand-computed directed expectations.
module tb_seq_scan_ctrl;
    localparam int CNT_W = 4;
    localparam int LAT   = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_scan_ctrl_if #(.WORD_W(8),  .CNT_W(CNT_W)) bus8 ();
    seq_scan_ctrl_if #(.WORD_W(16), .CNT_W(CNT_W)) bus16 ();
    logic din8, clr8, y8, busy8;
    logic din16, clr16, y16, busy16;

    seq_scan_ctrl #(.WORD_W(8), .CNT_W(CNT_W), .DET_LAT(LAT), .IDLE_BIT(1'b1)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8),
        .det_din(din8), .det_clear(clr8), .det_y(y8), .busy(busy8)
    );

    seq_scan_ctrl #(.WORD_W(16), .CNT_W(CNT_W), .DET_LAT(LAT), .IDLE_BIT(1'b1)) dut16 (
        .clk(clk), .reset(reset), .bus(bus16),
        .det_din(din16), .det_clear(clr16), .det_y(y16), .busy(busy16)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model: a word in flight is described only by its accept cycle; every
    // output follows from the offset k = cycle - accept_cycle.
    typedef struct {
        bit          active;
        int          tacc;
        bit          keep;
        logic [15:0] word;
        int          cnt;
    } mdl_t;
    mdl_t m [2];

    task automatic step(input int d, input int w, input logic rst,
                        input logic rdy, input logic vld, input logic [CNT_W-1:0] cnt,
                        input logic din, input logic clr, input logic bsy,
                        input logic iv, input logic [15:0] idata, input logic ik,
                        input logic ordy, input logic y);
        logic  e_rdy, e_vld, e_din, e_clr, e_bsy;
        int    e_cnt, k, s;
        bit    counting, reporting;
        string tag;
        e_rdy = 1'b0; e_vld = 1'b0; e_din = 1'b1; e_clr = 1'b0; e_bsy = 1'b0;
        e_cnt = 0; counting = 1'b0; reporting = 1'b0;
        tag = (d == 0) ? "w8" : "w16";
        if (rst) begin
            e_clr = 1'b1;
        end else if (!m[d].active) begin
            e_rdy = 1'b1;
        end else begin
            k = cyc - m[d].tacc;
            s = m[d].keep ? 1 : 2;
            e_bsy = 1'b1;
            if (k < s) begin
                e_clr = 1'b1;
            end else if (k < s + w) begin
                e_din = m[d].word[w - 1 - (k - s)];
                counting = 1'b1;
            end else if (k < s + w + LAT) begin
                counting = 1'b1;
            end else begin
                e_vld = 1'b1;
                e_cnt = (m[d].cnt > CMAX) ? CMAX : m[d].cnt;
                reporting = 1'b1;
            end
        end
        check({tag, ".in_ready"},  32'(rdy), 32'(e_rdy));
        check({tag, ".out_valid"}, 32'(vld), 32'(e_vld));
        check({tag, ".out_count"}, 32'(cnt), e_cnt);
        check({tag, ".det_din"},   32'(din), 32'(e_din));
        check({tag, ".det_clear"}, 32'(clr), 32'(e_clr));
        check({tag, ".busy"},      32'(bsy), 32'(e_bsy));

        if (rst) begin
            m[d].active = 1'b0;
        end else if (!m[d].active) begin
            if (iv) begin
                m[d].active = 1'b1;
                m[d].tacc   = cyc;
                m[d].keep   = ik;
                m[d].word   = idata;
                m[d].cnt    = 0;
            end
        end else begin
            if (counting && y) m[d].cnt++;
            if (reporting && ordy) m[d].active = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        step(0, 8, reset, bus8.in_ready, bus8.out_valid, bus8.out_count, din8, clr8, busy8,
             bus8.in_valid, 16'(bus8.in_data), bus8.in_keep, bus8.out_ready, y8);
        step(1, 16, reset, bus16.in_ready, bus16.out_valid, bus16.out_count, din16, clr16, busy16,
             bus16.in_valid, bus16.in_data, bus16.in_keep, bus16.out_ready, y16);
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a word from the current cycle; returns at the negedge of the accept cycle.
    task automatic offer(input int d, input logic [15:0] data, input logic keep);
        bit ok;
        ok = 1'b0;
        if (d == 0) begin
            bus8.in_valid = 1'b1; bus8.in_data = data[7:0]; bus8.in_keep = keep;
        end else begin
            bus16.in_valid = 1'b1; bus16.in_data = data; bus16.in_keep = keep;
        end
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (d == 0) ? bus8.in_ready : bus16.in_ready;
            if (!ok) tick();
        end
        check("accept_wait", 32'(ok), 1);
    endtask

    task automatic wait_valid(input int d);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            @(negedge clk);
            seen = (d == 0) ? bus8.out_valid : bus16.out_valid;
        end
        check("out_valid_wait", 32'(seen), 1);
    endtask

    bit a5_seq [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_keep = 1'b0; bus8.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.in_keep = 1'b0; bus16.out_ready = 1'b1;
        y8 = 1'b0; y16 = 1'b0;

        // Reset values.
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("rst.in_ready",  32'(bus8.in_ready), 0);
            check("rst.det_clear", 32'(clr8), 1);
            check("rst.det_din",   32'(din8), 1);
            check("rst.out_count", 32'(bus8.out_count), 0);
        end
        tick(); reset = 1'b0;
        @(negedge clk);
        check("rst.first_ready", 32'(bus8.in_ready), 1);

        // 8'hA5 with a clear pulse: SHIFT T+2..T+9, result at T+12.
        tick(); offer(0, 16'h00A5, 1'b0);
        tick(); bus8.in_valid = 1'b0;
        @(negedge clk);
        check("a5.clear", 32'(clr8), 1);
        for (int i = 0; i < 8; i++) begin
            tick(); @(negedge clk);
            check("a5.det_din", 32'(din8), 32'(a5_seq[i]));
            check("a5.no_clear", 32'(clr8), 0);
        end
        tick(); @(negedge clk); check("a5.valid_T10", 32'(bus8.out_valid), 0);
        tick(); @(negedge clk); check("a5.valid_T11", 32'(bus8.out_valid), 0);
        tick(); @(negedge clk); check("a5.valid_T12", 32'(bus8.out_valid), 1);

        // in_keep=1: no clear, SHIFT from T+1, result at T+11.
        tick(); offer(0, 16'h003C, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) bus8.in_valid = 1'b0;
            @(negedge clk);
            if (k <= 10) check("keep.no_clear", 32'(clr8), 0);
            if (k == 1)  check("keep.din_T1", 32'(din8), 0);
            if (k == 3)  check("keep.din_T3", 32'(din8), 1);
            if (k == 8)  check("keep.din_T8", 32'(din8), 0);
            if (k == 10) check("keep.valid_T10", 32'(bus8.out_valid), 0);
            if (k == 11) check("keep.valid_T11", 32'(bus8.out_valid), 1);
        end

        // Three detector pulses, then 5 cycles of back-pressure with pulses that must not count.
        tick(); bus8.out_ready = 1'b0; offer(0, 16'h005A, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) bus8.in_valid = 1'b0;
            y8 = (k == 3 || k == 8 || k == 11);
            @(negedge clk);
        end
        for (int k = 12; k <= 16; k++) begin
            tick();
            y8 = 1'b1;
            bus8.in_valid = 1'b1; bus8.in_data = 8'h00; bus8.in_keep = 1'b1;
            @(negedge clk);
            check("bp.out_valid", 32'(bus8.out_valid), 1);
            check("bp.out_count", 32'(bus8.out_count), 3);
            check("bp.in_ready",  32'(bus8.in_ready), 0);
        end
        tick(); bus8.out_ready = 1'b1;
        @(negedge clk);
        check("bp.release_valid", 32'(bus8.out_valid), 1);
        check("bp.release_count", 32'(bus8.out_count), 3);
        check("bp.release_ready", 32'(bus8.in_ready), 0);
        tick(); @(negedge clk);
        check("bp.accept_ready", 32'(bus8.in_ready), 1);
        check("bp.accept_count", 32'(bus8.out_count), 0);
        tick(); bus8.in_valid = 1'b0; y8 = 1'b0;
        wait_valid(0);
        check("bp.next_count", 32'(bus8.out_count), 0);

        // Two chained in_keep words with det_y held high: 10 then 10.
        tick(); y8 = 1'b1; offer(0, 16'h00C3, 1'b1);
        wait_valid(0);
        check("chain.count1", 32'(bus8.out_count), 10);
        tick(); @(negedge clk);
        check("chain.accept2", 32'(bus8.in_ready), 1);
        tick(); bus8.in_valid = 1'b0;
        wait_valid(0);
        check("chain.count2", 32'(bus8.out_count), 10);
        tick(); y8 = 1'b0;

        // 16-bit word with det_y held high saturates at 15.
        y16 = 1'b1; offer(1, 16'hBEEF, 1'b0);
        tick(); bus16.in_valid = 1'b0;
        wait_valid(1);
        check("sat.count16", 32'(bus16.out_count), 15);
        tick(); y16 = 1'b0;

        // Reset at SHIFT bit 4 discards the word and its count.
        offer(0, 16'h00FF, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) bus8.in_valid = 1'b0;
            y8 = (k >= 2);
            @(negedge clk);
        end
        tick(); reset = 1'b1;
        @(negedge clk);
        check("abort.rst_ready", 32'(bus8.in_ready), 0);
        check("abort.rst_clear", 32'(clr8), 1);
        check("abort.rst_busy",  32'(busy8), 0);
        tick(); reset = 1'b0; y8 = 1'b0;
        @(negedge clk);
        check("abort.idle_ready", 32'(bus8.in_ready), 1);
        check("abort.idle_valid", 32'(bus8.out_valid), 0);
        check("abort.idle_busy",  32'(busy8), 0);
        tick(); offer(0, 16'h0000, 1'b0);
        tick(); bus8.in_valid = 1'b0;
        wait_valid(0);
        check("abort.no_stale", 32'(bus8.out_count), 0);

        // Random traffic on both instances, with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            tick();
            reset = ($urandom_range(0, 199) == 0);
            bus8.in_valid   = ($urandom_range(0, 2) != 0);
            bus8.in_data    = 8'($urandom);
            bus8.in_keep    = 1'($urandom);
            bus8.out_ready  = ($urandom_range(0, 3) != 0);
            y8              = 1'($urandom);
            bus16.in_valid  = ($urandom_range(0, 2) != 0);
            bus16.in_data   = 16'($urandom);
            bus16.in_keep   = 1'($urandom);
            bus16.out_ready = ($urandom_range(0, 3) != 0);
            y16             = 1'($urandom);
        end
        tick();
        reset = 1'b0;
        bus8.in_valid = 1'b0; bus16.in_valid = 1'b0;
        bus8.out_ready = 1'b1; bus16.out_ready = 1'b1;
        y8 = 1'b0; y16 = 1'b0;
        repeat (30) tick();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning bits per scanned word.
REQ-002 SHALL have parameter CNT_W, default 4, meaning width of the detection count.
REQ-003 SHALL have parameter DET_LAT, default 2, meaning drain cycles after the last bit.
REQ-004 SHALL have parameter IDLE_BIT, default 1, meaning the det_din value driven during drain.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, word offered.
REQ-008 SHALL have port in_data, input, WORD_W, word to scan, MSB first.
REQ-009 SHALL have port in_keep, input, 1, sampled with in_data; 1 = keep detector context (skip clear).
REQ-010 SHALL have port in_ready, output, 1, word accepted when in_valid && in_ready.
REQ-011 SHALL have port det_din, output, 1, serial bit to the detector.
REQ-012 SHALL have port det_clear, output, 1, synchronous clear to the detector.
REQ-013 SHALL have port det_y, input, 1, detector Moore output.
REQ-014 SHALL have port out_valid, output, 1, result available.
REQ-015 SHALL have port out_count, output, CNT_W, detections counted for the word.
REQ-016 SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, CLEAR, SHIFT, DRAIN and REPORT, with registered state.
REQ-019 SHALL drive in_ready=1 only in IDLE; on accept it SHALL load the shift register and in_keep, then go to CLEAR (in_keep=0) or SHIFT (in_keep=1).
REQ-020 SHALL assert det_clear=1 for exactly one cycle in CLEAR, then go to SHIFT.
REQ-021 SHALL clear the count to 0 on accept.
REQ-022 SHALL stay in SHIFT exactly WORD_W cycles, with det_din = the shift-register MSB, shifting left by one each cycle.
REQ-023 SHALL stay in DRAIN exactly DET_LAT cycles with det_din=IDLE_BIT, then go to REPORT; DET_LAT=0 SHALL go directly from SHIFT to REPORT.
REQ-024 SHALL drive det_din=IDLE_BIT in IDLE, CLEAR and REPORT.
REQ-025 SHALL increment the count by 1 in every SHIFT or DRAIN cycle with det_y=1, saturating at 2^CNT_W-1 with no wrap.
REQ-026 SHALL ignore det_y in IDLE, CLEAR and REPORT.
REQ-027 SHALL hold out_valid=1 in REPORT, with out_count stable until out_ready=1, then return to IDLE.
REQ-028 SHALL hold out_count=0 whenever out_valid=0.
REQ-029 SHALL have a latency from the accept cycle T to out_valid of 2+WORD_W+DET_LAT cycles (in_keep=0) or 1+WORD_W+DET_LAT cycles (in_keep=1).
REQ-030 SHALL not accept a new word in the cycle out_ready completes REPORT; earliest next accept is the following IDLE cycle.
REQ-031 SHALL ignore in_valid, in_data and in_keep outside IDLE.

Reset
REQ-032 SHALL, while reset=1, enter IDLE and clear the count and shift register.
REQ-033 SHALL drive, while reset=1: in_ready=0, out_valid=0, out_count=0, busy=0, det_din=IDLE_BIT, det_clear=1.
REQ-034 SHALL, on reset in any state (including mid-SHIFT), discard the word with no result reported; in_ready=1 from the first cycle after reset deasserts.

Structure
REQ-035 SHALL place the state encodings (3-bit) and the parameter defaults in shared package seq_scan_pkg.
REQ-036 SHALL use one sub-module, sat_counter (CNT_W-bit, sync clear, enable, saturate), for the count.
REQ-037 SHALL keep bit-index and drain counters inline, each sized $clog2 of its maximum plus 1.

Verification
REQ-038 SHALL verify that in_data=8'hA5, in_keep=0 gives one det_clear pulse, then det_din 1,0,1,0,0,1,0,1 on SHIFT cycles T+2..T+9, and out_valid at T+12.
REQ-039 SHALL verify that a bench pulsing det_y in 3 SHIFT/DRAIN cycles gives out_count=3; det_y pulsed in REPORT/IDLE is not counted.
REQ-040 SHALL verify that with CNT_W=4 and det_y held high for all 10 SHIFT+DRAIN cycles of two chained in_keep words, out_count=10 then 10; with WORD_W=16, out_count=15 (saturated).
REQ-041 SHALL verify that out_ready held low 5 cycles keeps out_valid=1, out_count constant and in_ready=0; an accept occurs 1 cycle after out_ready.
REQ-042 SHALL verify that reset asserted at SHIFT bit 4 gives IDLE, out_valid=0, in_ready=1 in the next cycle and no stale count on the next word.
REQ-043 SHALL verify that in_keep=1 gives no det_clear pulse, SHIFT starting at T+1 and out_valid at T+11.
